// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its sequencing controller:
// hazard/status inputs toward the controller, stage enables and counters back.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned CNT_W = 16
);
  logic [15:0]      if_instr;
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_rs_vld;
  logic             id_rt_vld;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_load;
  logic             br_taken;
  logic             imem_busy;
  logic             dmem_busy;
  logic             halt_wb;

  logic             pc_en;
  logic             ifid_en;
  logic [15:0]      ifid_d;
  logic             ifid_nop;
  logic             idex_en;
  logic             idex_nop;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output if_instr, id_rs, id_rt, id_rs_vld, id_rt_vld, ex_rd, ex_load,
           br_taken, imem_busy, dmem_busy, halt_wb,
    input  pc_en, ifid_en, ifid_d, ifid_nop, idex_en, idex_nop, exmem_en,
           memwb_en, halted, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  if_instr, id_rs, id_rt, id_rs_vld, id_rt_vld, ex_rd, ex_load,
           br_taken, imem_busy, dmem_busy, halt_wb,
    output pc_en, ifid_en, ifid_d, ifid_nop, idex_en, idex_nop, exmem_en,
           memwb_en, halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle advance/hold/bubble decisions for the
// PC and stage registers, with data-wait and halt states plus stall/flush counters.
module pipe_hazard_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int unsigned RA_W      = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DWAIT = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  logic [1:0]       state_q, state_nx;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_nop, idex_nop;
  logic             load_use;
  logic [RA_W-1:0]  rd;

  assign rd       = bus.ex_rd;
  // Register 0 is hardwired, so a load targeting it never needs an interlock.
  assign load_use = bus.ex_load && (rd != '0) &&
                    ((bus.id_rs_vld && (bus.id_rs == rd)) ||
                     (bus.id_rt_vld && (bus.id_rt == rd)));

  // Next state, stage enables and counter strobes.
  always_comb begin
    state_nx  = state_q;
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    idex_en   = 1'b1;
    exmem_en  = 1'b1;
    memwb_en  = 1'b1;
    ifid_nop  = 1'b0;
    idex_nop  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      ifid_nop = 1'b1;
      idex_nop = 1'b1;
    end else if (state_q == HALT) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
    end else if (state_q == DWAIT && bus.dmem_busy) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
      stall_inc = 1'b1;
    end else begin
      // RUN, or the release cycle of DWAIT, which behaves exactly like RUN.
      state_nx = RUN;
      if (bus.halt_wb) begin
        state_nx = HALT;
      end else if (bus.dmem_busy) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        state_nx  = DWAIT;
        stall_inc = 1'b1;
      end else if (bus.br_taken) begin
        ifid_nop  = 1'b1;
        idex_nop  = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_nop  = 1'b1;
        stall_inc = 1'b1;
      end else if (bus.imem_busy) begin
        pc_en     = 1'b0;
        ifid_nop  = 1'b1;
        stall_inc = 1'b1;
      end
    end
  end

  // State and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_nx;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifid_en   = ifid_en;
  assign bus.ifid_nop  = ifid_nop;
  assign bus.ifid_d    = ifid_nop ? NOP_INSTR : bus.if_instr;
  assign bus.idex_en   = idex_en;
  assign bus.idex_nop  = idex_nop;
  assign bus.exmem_en  = exmem_en;
  assign bus.memwb_en  = memwb_en;
  assign bus.halted    = (state_q == HALT);
  assign bus.state     = state_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit instruction pipeline registers, which have an enable and load NOP 16'h0800.
- Decides each cycle which stage registers advance, hold, or load a NOP bubble.
- Covers load-use stalls, taken-branch flushes, instruction-fetch wait, data-memory wait and halt.
- Sits beside the hazard/forwarding logic.
- Drives the `en` pins of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus the IF/ID data mux.

Parameters:
- NOP_INSTR, 16'h0800, encoding inserted as a bubble.
- RA_W, 4, register-address width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_instr  in  16  instruction from instruction memory.
- id_rs  in  RA_W  source reg 1 of the instruction in ID.
- id_rt  in  RA_W  source reg 2 of the instruction in ID.
- id_rs_vld  in  1  ID instruction reads rs.
- id_rt_vld  in  1  ID instruction reads rt.
- ex_rd  in  RA_W  destination reg of the instruction in EX.
- ex_load  in  1  EX instruction is a load.
- br_taken  in  1  branch resolved taken in EX this cycle.
- imem_busy  in  1  fetch not ready this cycle.
- dmem_busy  in  1  data memory not ready this cycle.
- halt_wb  in  1  HLT instruction in WB.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID enable.
- ifid_d  out  16  IF/ID data input: NOP_INSTR when ifid_nop, else if_instr.
- ifid_nop  out  1  IF/ID loads bubble.
- idex_en  out  1  ID/EX enable.
- idex_nop  out  1  ID/EX loads bubble (control bits cleared).
- exmem_en  out  1  EX/MEM enable.
- memwb_en  out  1  MEM/WB enable.
- halted  out  1  pipeline frozen after HLT.
- state  out  2  FSM state: RUN=0, DWAIT=1, HALT=2.
- stall_cnt  out  CNT_W  stall-cycle count.
- flush_cnt  out  CNT_W  branch-flush count.

Behaviour:
- Reset (asynchronous, any time, including mid-stall):
  - state=RUN, stall_cnt=0, flush_cnt=0, halted=0.
  - While rst=1: all *_en=1, ifid_nop=1, idex_nop=1, so ifid_d=NOP_INSTR.
- Timing:
  - Enables and nop outputs are combinational from state and inputs (zero latency).
  - state, halted and the counters are registered.
  - halted = (state==HALT).
- Default (RUN, no event): all enables=1, nops=0.
- Events in RUN, highest priority first:
  1. halt_wb: outputs as default this cycle; next state HALT.
  2. dmem_busy: all enables=0; next state DWAIT; stall_cnt++.
  3. br_taken: pc_en=ifid_en=idex_en=exmem_en=memwb_en=1, ifid_nop=1, idex_nop=1; flush_cnt++.
     - Overrides load-use and imem_busy; both are squashed instructions.
  4. Load-use: ex_load & ex_rd!=0 & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
     - pc_en=0, ifid_en=0, idex_en=1, idex_nop=1, exmem/memwb_en=1; stall_cnt++.
     - Register 0 never causes a stall.
  5. imem_busy: pc_en=0, ifid_en=1, ifid_nop=1, rest default; stall_cnt++.
- DWAIT:
  - dmem_busy=1: all enables=0, stall_cnt++, stay in DWAIT.
  - dmem_busy=0: outputs and counters evaluated exactly as RUN (events 1–5); next state per those rules, else RUN.
  - A held load-use condition re-evaluates normally on the release cycle.
- HALT:
  - All enables=0, nops=0, counters frozen.
  - Leave only via rst.
  - Inputs ignored.
- Counters saturate at all-ones; no wrap.
- A single cycle increments at most one counter.
- ifid_d is purely combinational in every state.

Test Plan:
- Reset: assert rst mid-DWAIT with dmem_busy=1 -> state=0, counters=0, all en=1, ifid_d=16'h0800 immediately (no clock edge needed).
- Load-use: ex_load=1, ex_rd=3, id_rs=3, id_rs_vld=1 -> pc_en=0, ifid_en=0, idex_nop=1, stall_cnt 0->1. Repeat with ex_rd=0 -> no stall, stall_cnt unchanged.
- Branch flush: br_taken=1 together with imem_busy=1 and a load-use match -> ifid_nop=1, idex_nop=1, pc_en=1, flush_cnt+1, stall_cnt unchanged.
- Data wait: dmem_busy=1 for 3 cycles, then 0 -> state 1 for 3 cycles with all en=0, stall_cnt+=3; release cycle all en=1, state=0 next.
- Halt: halt_wb=1 for one cycle -> next cycle halted=1, state=2, all en=0; pulses on br_taken/dmem_busy cause no change.
- Saturation: preload by driving 65540 imem_busy cycles -> stall_cnt=16'hFFFF, holds there.
